// File: rtl/vita_tx_scheduler.sv
// Timed-release scheduler between the TX sample FIFO and the DSP strobe domain.
// Optional feature: define VITA_TX_SCHED_EOB_ACK_EN to post an ack event on every EOB pop.
module vita_tx_scheduler #(
  parameter int unsigned BASE    = 0,
  parameter int unsigned MAXCHAN = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  input  logic [63:0]               vita_time,
  input  logic [5+64+16+32*MAXCHAN-1:0] sample_fifo_i,
  input  logic                      sample_fifo_src_rdy_i,
  output logic                      sample_fifo_dst_rdy_o,
  input  logic                      strobe,
  output logic [32*MAXCHAN-1:0]     sample_o,
  output logic                      run,
  output logic                      error,
  output logic                      ack,
  output logic [31:0]               error_code
);

  localparam int unsigned SAMP_W       = 32 * MAXCHAN;
  localparam int unsigned WIDTH        = 5 + 64 + 16 + SAMP_W;
  localparam int unsigned SEQ_LSB      = 64;
  localparam int unsigned EOP_BIT      = 80;
  localparam int unsigned EOB_BIT      = 81;
  localparam int unsigned HAS_TIME_BIT = 83;
  localparam int unsigned SEQ_ERR_BIT  = 84;

  localparam logic [15:0] CODE_UNDERFLOW = 16'h0002;
  localparam logic [15:0] CODE_SEQ_ERR   = 16'h0004;
  localparam logic [15:0] CODE_LATE      = 16'h0008;
  localparam logic [1:0]  POL_NEXT_PKT   = 2'b01;
  localparam logic [1:0]  POL_NEXT_BURST = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TIME, S_RUN, S_DROP} state_t;

  state_t state, state_next, fail_state;

  logic [1:0]        policy;
  logic              drop_eob;
  logic [3:0]        last_seq;
  logic              pop_run_c, pop_drop_c, err_c, run_d;
  logic [15:0]       code_c;
  logic [3:0]        code_seq_c;
  logic [SAMP_W-1:0] sample_d;

  // FIFO word fields
  logic [63:0]       w_time;
  logic [3:0]        w_seq;
  logic              w_eop, w_eob, w_has_time, w_seq_err;
  logic [SAMP_W-1:0] w_samples;

  assign w_time     = sample_fifo_i[63:0];
  assign w_seq      = sample_fifo_i[SEQ_LSB +: 4];
  assign w_eop      = sample_fifo_i[EOP_BIT];
  assign w_eob      = sample_fifo_i[EOB_BIT];
  assign w_has_time = sample_fifo_i[HAS_TIME_BIT];
  assign w_seq_err  = sample_fifo_i[SEQ_ERR_BIT];
  assign w_samples  = sample_fifo_i[WIDTH-1 -: SAMP_W];

  // sob and the reserved zero field carry no meaning here
  logic unused_bits;
  assign unused_bits = &{1'b0, set_data[31:2], sample_fifo_i[82], sample_fifo_i[79:68]};

  // Recovery destination after an error event
  assign fail_state = (policy == POL_NEXT_PKT || policy == POL_NEXT_BURST) ? S_DROP : S_IDLE;

`ifdef VITA_TX_SCHED_EOB_ACK_EN
  localparam logic [15:0] CODE_ACK = 16'h0001;
  logic ack_c;
`endif

  always_comb begin
    state_next = state;
    pop_run_c  = 1'b0;
    pop_drop_c = 1'b0;
    err_c      = 1'b0;
    code_c     = 16'h0000;
    code_seq_c = last_seq;
`ifdef VITA_TX_SCHED_EOB_ACK_EN
    ack_c      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (sample_fifo_src_rdy_i) begin
          if (w_seq_err) begin
            err_c      = 1'b1;
            code_c     = CODE_SEQ_ERR;
            code_seq_c = w_seq;
            state_next = fail_state;
          end else if (w_has_time) begin
            state_next = S_WAIT_TIME;
          end else begin
            state_next = S_RUN;
          end
        end
      end
      S_WAIT_TIME: begin
        if (!sample_fifo_src_rdy_i) begin
          state_next = S_IDLE;
        end else if (vita_time == w_time) begin
          state_next = S_RUN;
        end else if (vita_time > w_time) begin
          err_c      = 1'b1;
          code_c     = CODE_LATE;
          code_seq_c = w_seq;
          state_next = fail_state;
        end
      end
      S_RUN: begin
        if (strobe) begin
          if (sample_fifo_src_rdy_i) begin
            pop_run_c = 1'b1;
            if (w_eob) begin
              state_next = S_IDLE;
`ifdef VITA_TX_SCHED_EOB_ACK_EN
              ack_c      = 1'b1;
              code_c     = CODE_ACK;
              code_seq_c = w_seq;
`endif
            end
          end else begin
            // underflow has no word at the head; report the last word played
            err_c      = 1'b1;
            code_c     = CODE_UNDERFLOW;
            state_next = fail_state;
          end
        end
      end
      S_DROP: begin
        if (sample_fifo_src_rdy_i) begin
          pop_drop_c = 1'b1;
          if (drop_eob ? w_eob : w_eop) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Last sample stays visible while run is high, zeroed once run falls
  assign run_d    = (state_next == S_RUN) || pop_run_c;
  assign sample_d = pop_run_c ? w_samples : (run_d ? sample_o : '0);

  assign sample_fifo_dst_rdy_o = (pop_run_c || pop_drop_c) && !reset && !clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      run        <= 1'b0;
      sample_o   <= '0;
      error      <= 1'b0;
      error_code <= 32'h0;
      policy     <= 2'b00;
      drop_eob   <= 1'b0;
      last_seq   <= 4'h0;
    end else begin
      if (set_stb && set_addr == 8'(BASE)) policy <= set_data[1:0];
      if (clear) begin
        state    <= S_IDLE;
        run      <= 1'b0;
        sample_o <= '0;
        error    <= 1'b0;
      end else begin
        state    <= state_next;
        run      <= run_d;
        sample_o <= sample_d;
        error    <= err_c;
        if (sample_fifo_dst_rdy_o) last_seq <= w_seq;
        if (state_next == S_DROP && state != S_DROP) drop_eob <= (policy == POL_NEXT_BURST);
`ifdef VITA_TX_SCHED_EOB_ACK_EN
        if (err_c || ack_c) error_code <= {code_seq_c, 12'h000, code_c};
`else
        if (err_c) error_code <= {code_seq_c, 12'h000, code_c};
`endif
      end
    end
  end

`ifdef VITA_TX_SCHED_EOB_ACK_EN
  always_ff @(posedge clk) begin
    if (reset || clear) ack <= 1'b0;
    else                ack <= ack_c;
  end
`else
  assign ack = 1'b0;
`endif

endmodule

// File: tb/tb_vita_tx_scheduler.sv
// Directed bench for vita_tx_scheduler with a queue-backed sample FIFO model.
module tb_vita_tx_scheduler;
  localparam int unsigned MAXCHAN = 1;
  localparam int unsigned WIDTH   = 5 + 64 + 16 + 32 * MAXCHAN;

  logic              clk = 1'b0;
  logic              reset, clear, set_stb, strobe;
  logic [7:0]        set_addr;
  logic [31:0]       set_data;
  logic [63:0]       vita_time;
  logic [WIDTH-1:0]  sample_fifo_i;
  logic              src_rdy, dst_rdy, run, error, ack;
  logic [31:0]       sample_o, error_code;

  vita_tx_scheduler #(.BASE(0), .MAXCHAN(MAXCHAN)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .vita_time(vita_time),
    .sample_fifo_i(sample_fifo_i),
    .sample_fifo_src_rdy_i(src_rdy),
    .sample_fifo_dst_rdy_o(dst_rdy),
    .strobe(strobe), .sample_o(sample_o), .run(run),
    .error(error), .ack(ack), .error_code(error_code)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] q[$];
  logic [31:0]      got[$];
  longint           vt, rise_vt;
  int               total, bad, pops, errs, acks, run_hi;
  logic             did_pop, prev_run;
  logic [31:0]      first_code;

  function automatic logic [WIDTH-1:0] mk(input logic [31:0] s, input logic se, input logic ht,
                                          input logic sob, input logic eob, input logic eop,
                                          input logic [3:0] seq, input logic [63:0] t);
    return {s, se, ht, sob, eob, eop, 12'd0, seq, t};
  endfunction

  task automatic drive_fifo();
    src_rdy       = (q.size() > 0);
    sample_fifo_i = (q.size() > 0) ? q[0] : '0;
  endtask

  // One clock: record the pop decision, advance, then observe outputs
  task automatic cyc();
    #1;
    did_pop = dst_rdy && src_rdy;
    @(posedge clk);
    if (did_pop && q.size() > 0) void'(q.pop_front());
    #1;
    if (did_pop) begin pops++; got.push_back(sample_o); end
    errs   += int'(error);
    acks   += int'(ack);
    run_hi += int'(run);
    if (error && errs == 1) first_code = error_code;
    if (run && !prev_run && rise_vt < 0) rise_vt = vt;
    prev_run  = run;
    vt++;
    vita_time = vt;
    drive_fifo();
  endtask

  task automatic clr_obs();
    pops = 0; errs = 0; acks = 0; run_hi = 0; rise_vt = -1; first_code = 32'h0;
    got.delete();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_policy(input logic [1:0] p);
    set_stb = 1'b1; set_addr = 8'd0; set_data = {30'd0, p};
    cyc();
    set_stb = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; prev_run = 1'b0;
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    strobe = 1'b0; vt = 0; vita_time = 0;
    clr_obs();
    drive_fifo();
    repeat (3) cyc();
    check("rst_run", 64'(run), 64'd0);
    check("rst_sample", 64'(sample_o), 64'd0);
    check("rst_dst_rdy", 64'(dst_rdy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_code", 64'(error_code), 64'd0);
    reset = 1'b0;
    cyc();

    // Timed burst released exactly at send_time
    clr_obs();
    vt = 990; vita_time = vt; strobe = 1'b1;
    q.push_back(mk(32'd1000, 0, 1, 1, 0, 0, 4'd1, 64'd1000));
    q.push_back(mk(32'd1001, 0, 0, 0, 0, 0, 4'd2, 64'd0));
    q.push_back(mk(32'd1002, 0, 0, 0, 0, 0, 4'd3, 64'd0));
    q.push_back(mk(32'd1003, 0, 0, 0, 1, 1, 4'd4, 64'd0));
    drive_fifo();
    repeat (20) cyc();
    check("t1_rise_time", 64'(rise_vt), 64'd1000);
    check("t1_pops", 64'(pops), 64'd4);
    for (int i = 0; i < 4; i++) check("t1_sample", 64'(got[i]), 64'(1000 + i));
    check("t1_errs", 64'(errs), 64'd0);
    check("t1_run_end", 64'(run), 64'd0);
    check("t1_sample_end", 64'(sample_o), 64'd0);
`ifdef VITA_TX_SCHED_EOB_ACK_EN
    check("t1_acks", 64'(acks), 64'd1);
    check("t1_code", 64'(error_code), 64'h4000_0001);
`else
    check("t1_acks", 64'(acks), 64'd0);
    check("t1_code", 64'(error_code), 64'h0);
`endif

    // Late burst dropped to eob
    strobe = 1'b0;
    set_policy(2'b10);
    clr_obs();
    vt = 990; vita_time = vt;
    q.push_back(mk(32'd2000, 0, 1, 1, 0, 0, 4'd2, 64'd900));
    q.push_back(mk(32'd2001, 0, 0, 0, 0, 1, 4'd3, 64'd0));
    q.push_back(mk(32'd2002, 0, 0, 0, 0, 0, 4'd4, 64'd0));
    q.push_back(mk(32'd2003, 0, 0, 0, 1, 1, 4'd5, 64'd0));
    drive_fifo();
    repeat (12) cyc();
    check("t2_errs", 64'(errs), 64'd1);
    check("t2_code", 64'(first_code), 64'h2000_0008);
    check("t2_pops", 64'(pops), 64'd4);
    check("t2_run_hi", 64'(run_hi), 64'd0);
    check("t2_fifo_left", 64'(q.size()), 64'd0);
    check("t2_dst_rdy", 64'(dst_rdy), 64'd0);

    // Untimed packet followed by underflow
    set_policy(2'b00);
    clr_obs();
    strobe = 1'b1;
    q.push_back(mk(32'h11, 0, 0, 1, 0, 0, 4'd4, 64'd0));
    q.push_back(mk(32'h22, 0, 0, 0, 0, 0, 4'd5, 64'd0));
    q.push_back(mk(32'h33, 0, 0, 0, 0, 1, 4'd6, 64'd0));
    drive_fifo();
    repeat (8) cyc();
    check("t3_pops", 64'(pops), 64'd3);
    check("t3_s0", 64'(got[0]), 64'h11);
    check("t3_s1", 64'(got[1]), 64'h22);
    check("t3_s2", 64'(got[2]), 64'h33);
    check("t3_errs", 64'(errs), 64'd1);
    check("t3_code", 64'(first_code), 64'h6000_0002);
    check("t3_run_hi", 64'(run_hi), 64'd4);
    check("t3_run_end", 64'(run), 64'd0);

    // Sequence error dropped to eop, next packet plays
    set_policy(2'b01);
    clr_obs();
    q.push_back(mk(32'hdead, 1, 0, 1, 0, 1, 4'd5, 64'd0));
    q.push_back(mk(32'hb1, 0, 0, 1, 0, 0, 4'd6, 64'd0));
    q.push_back(mk(32'hb2, 0, 0, 0, 1, 1, 4'd7, 64'd0));
    drive_fifo();
    repeat (10) cyc();
    check("t4_errs", 64'(errs), 64'd1);
    check("t4_code", 64'(first_code), 64'h5000_0004);
    check("t4_pops", 64'(pops), 64'd3);
    check("t4_drop_sample", 64'(got[0]), 64'h0);
    check("t4_b1", 64'(got[1]), 64'hb1);
    check("t4_b2", 64'(got[2]), 64'hb2);
`ifdef VITA_TX_SCHED_EOB_ACK_EN
    check("t4_acks", 64'(acks), 64'd1);
    check("t4_code_end", 64'(error_code), 64'h7000_0001);
`else
    check("t4_acks", 64'(acks), 64'd0);
    check("t4_code_end", 64'(error_code), 64'h5000_0004);
`endif

    // Reset in the middle of a burst
    clr_obs();
    for (int i = 0; i < 4; i++)
      q.push_back(mk(32'h51 + 32'(i), 0, 0, (i == 0), (i == 3), (i == 3), 4'(i), 64'd0));
    drive_fifo();
    repeat (3) cyc();
    check("t5_pre_pops", 64'(pops), 64'd2);
    reset = 1'b1;
    cyc();
    check("t5_no_pop", 64'(pops), 64'd2);
    check("t5_fifo_left", 64'(q.size()), 64'd2);
    check("t5_run", 64'(run), 64'd0);
    check("t5_error", 64'(error), 64'd0);
    check("t5_code", 64'(error_code), 64'h0);
    reset = 1'b0; strobe = 1'b0;
    q.delete();
    q.push_back(mk(32'h99, 1, 0, 1, 0, 1, 4'd9, 64'd0));
    drive_fifo();
    clr_obs();
    repeat (3) cyc();
    check("t5_wait_policy_pops", 64'(pops), 64'd0);
    check("t5_wait_policy_err", 64'(errs > 0), 64'd1);
    check("t5_wait_policy_code", 64'(first_code), 64'h9000_0004);

    // Clear keeps error_code
    clear = 1'b1;
    cyc();
    check("clr_error", 64'(error), 64'd0);
    check("clr_dst_rdy", 64'(dst_rdy), 64'd0);
    check("clr_code_kept", 64'(error_code), 64'h9000_0004);
    clear = 1'b0;
    q.delete();
    drive_fifo();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
